prop_delay_meter: RTL

- Synthesizable responder for the flip-flop characterization flow: measures launch-to-output delay by counting sample-clock cycles.
- The interval runs from a DUT clock edge (`trig_in`) to the expected transition on the DUT output (`dout_in`).
- Sits on the board side, opposite the stimulus/search engine. Returns one result per armed measurement over a valid/ready handshake, with timeout and wrong-level error flags.

---
 rtl/prop_delay_meter_pkg.sv | 15 +
 rtl/prop_delay_meter_sync_edge_det.sv | 32 +++
 rtl/prop_delay_meter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/prop_delay_meter_pkg.sv
// Shared types and default parameters for the propagation-delay meter.
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } pdm_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int TIMEOUT_DEF     = 1000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/prop_delay_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, plus rise/fall pulse
// detection against one extra registered copy of the synced level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign lvl  = r_sync[SYNC_STAGES-1];
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/prop_delay_meter.sv
// Counts sample-clock cycles from a synced trigger rise to the expected synced
// output edge, returning one result per arm over a valid/ready handshake.
module prop_delay_meter
  import pdm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             expect_rise,
  input  logic             trig_in,
  input  logic             dout_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_timeout,
  output logic             res_level_err
);

  pdm_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cycles;
  logic             r_exp_rise;
  logic             r_tmo;
  logic             r_lerr;

  logic             w_trig_rise;
  logic             w_unused_trig_lvl;
  logic             w_unused_trig_fall;
  logic             w_dout_lvl;
  logic             w_dout_rise;
  logic             w_dout_fall;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Identical depth on both paths so synchronizer latency cancels in the delay.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (trig_in),
    .lvl  (w_unused_trig_lvl),
    .rise (w_trig_rise),
    .fall (w_unused_trig_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_dout_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dout_in),
    .lvl  (w_dout_lvl),
    .rise (w_dout_rise),
    .fall (w_dout_fall)
  );

  assign w_match   = r_exp_rise ? w_dout_rise : w_dout_fall;
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cycles   <= '0;
      r_exp_rise <= 1'b0;
      r_tmo      <= 1'b0;
      r_lerr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_exp_rise <= expect_rise;
            r_cnt      <= '0;
            r_state    <= ARMED;
          end
        end
        ARMED: begin
          if (w_trig_rise) begin
            if (w_dout_lvl == r_exp_rise) begin
              r_lerr   <= 1'b1;
              r_cycles <= '0;
              r_state  <= DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          // A match in the timeout cycle still reports a real measurement.
          if (w_match) begin
            r_cycles <= w_cnt_nxt;
            r_state  <= DONE;
          end else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
            r_tmo    <= 1'b1;
            r_cycles <= CNT_W'(TIMEOUT);
            r_state  <= DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_cycles <= '0;
            r_tmo    <= 1'b0;
            r_lerr   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign res_valid     = (r_state == DONE);
  assign res_cycles    = r_cycles;
  assign res_timeout   = r_tmo;
  assign res_level_err = r_lerr;

endmodule
